tjmono2_data_arbiter: RTL and testbench

Two-source, 32-bit word arbiter that sits directly downstream of the TJ-Monopix2 RX core's readout FIFO port. It pops words from the RX FIFO and from one auxiliary FWFT source (TDC/TLU/timestamp), merges them with bounded-burst round-robin, and presents a single FWFT FIFO port to the readout path (SiTCP/USB FIFO). Words pass unmodified; each source already carries its own identifier in the upper bits.

---
 rtl/tjmono2_pkg.sv | 25 ++
 rtl/tjmono2_fwft_buf2.sv | 68 ++++++
 rtl/tjmono2_data_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tjmono2_data_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tjmono2_pkg.sv
// Shared types and constants for the TJ-Monopix2 readout data arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   WORD_W         readout word width
//   DEF_MAX_BURST  default burst limit per source when both sources have data
//   BCNT_W         width of the per-grant burst counter
//   grant_state_t  arbiter grant state
//   word_t         one readout word
package tjmono2_pkg;

    localparam int WORD_W        = 32;
    localparam int DEF_MAX_BURST = 16;
    localparam int BCNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_RX  = 2'd1,
        GRANT_AUX = 2'd2
    } grant_state_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage : tjmono2_pkg

// File: rtl/tjmono2_fwft_buf2.sv
// Two-entry first-word-fall-through buffer in front of the readout FIFO port.
// Latency: a word pushed in cycle N is visible on head_dat with empty=0 from cycle N+1.
// Backpressure: full=1 blocks pushes; pop while empty is ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears contents)
//   push, push_dat    write one word (dropped if full; the caller gates on full)
//   pop               consume the head word (ignored while empty)
//   head_dat          current head word, meaningful only while empty=0
//   empty, full       occupancy flags (0 entries / 2 entries)
module tjmono2_fwft_buf2
    import tjmono2_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_dat,
    input  logic  pop,
    output word_t head_dat,
    output logic  empty,
    output logic  full
);

    logic [1:0] cnt;
    word_t      head_q;
    word_t      tail_q;
    logic       do_push;
    logic       do_pop;

    assign empty    = (cnt == 2'd0);
    assign full     = (cnt == 2'd2);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    // Write into the first free slot.
                    if (cnt == 2'd0) begin
                        head_q <= push_dat;
                    end else begin
                        tail_q <= push_dat;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // Shift the tail forward; its content is don't-care when cnt was 1.
                    head_q <= tail_q;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // do_push implies cnt < 2 and do_pop implies cnt > 0, so cnt == 1:
                    // the new word replaces the departing head, occupancy unchanged.
                    head_q <= push_dat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : tjmono2_fwft_buf2

// File: rtl/tjmono2_data_arbiter.sv
// Merges the RX readout FIFO and one auxiliary FWFT source into one FWFT port with bounded-burst round-robin.
// Latency: a word popped upstream in cycle N appears on FIFO_DATA with FIFO_EMPTY=0 in cycle N+1.
// Backpressure: upstream pops stop while the 2-entry output buffer is full; FIFO_READ on empty is ignored.
//
// Ports:
//   FIFO_CLK, FIFO_RST_N                        clock, asynchronous active-low reset
//   RX_EN, AUX_EN                               quasi-static source enables
//   RX_FIFO_EMPTY/DATA/READ                     RX source FWFT port (READ is combinational)
//   AUX_FIFO_EMPTY/DATA/READ                    auxiliary source FWFT port
//   FIFO_READ, FIFO_EMPTY, FIFO_DATA            merged downstream FWFT port
//   RX_WORD_CNT, AUX_WORD_CNT                   saturating per-source word counters
// Build option: define TJMONO2_ARB_WORD_CNT_EN to implement the word counters;
// without it both counter ports are constant zero.
module tjmono2_data_arbiter
    import tjmono2_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 FIFO_CLK,
    input  logic                 FIFO_RST_N,
    input  logic                 RX_EN,
    input  logic                 AUX_EN,
    input  logic                 RX_FIFO_EMPTY,
    input  logic [WORD_W-1:0]    RX_FIFO_DATA,
    output logic                 RX_FIFO_READ,
    input  logic                 AUX_FIFO_EMPTY,
    input  logic [WORD_W-1:0]    AUX_FIFO_DATA,
    output logic                 AUX_FIFO_READ,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [WORD_W-1:0]    FIFO_DATA,
    output logic [CNT_WIDTH-1:0] RX_WORD_CNT,
    output logic [CNT_WIDTH-1:0] AUX_WORD_CNT
);

    localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(MAX_BURST);

    grant_state_t      state;
    grant_state_t      state_nxt;
    logic [BCNT_W-1:0] bcnt;

    logic  rx_elig;
    logic  aux_elig;
    logic  space;
    logic  buf_full;
    logic  rx_pop;
    logic  aux_pop;
    logic  push;
    word_t push_dat;

    assign rx_elig  = RX_EN && !RX_FIFO_EMPTY;
    assign aux_elig = AUX_EN && !AUX_FIFO_EMPTY;
    // Space is judged on the registered occupancy only, so a full buffer with a
    // concurrent downstream read still skips one pop; throughput stays 1/cycle
    // because the buffer then settles at one entry with push and pop each cycle.
    assign space    = !buf_full;

    // ------------------------------------------------------------------
    // Grant state and burst counter
    // ------------------------------------------------------------------
    always_ff @(posedge FIFO_CLK or negedge FIFO_RST_N) begin
        if (!FIFO_RST_N) begin
            state <= IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                // Every grant change (including entering or leaving IDLE) starts a fresh burst.
                bcnt <= '0;
            end else if ((rx_pop || aux_pop) && (bcnt != BURST_LIM)) begin
                // Saturates so a lone source can keep the grant without the count wrapping.
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_elig) begin
                    state_nxt = GRANT_RX;
                end else if (aux_elig) begin
                    state_nxt = GRANT_AUX;
                end
            end
            GRANT_RX: begin
                if (!rx_elig && !aux_elig) begin
                    state_nxt = IDLE;
                end else if (aux_elig && (!rx_elig || (bcnt == BURST_LIM))) begin
                    state_nxt = GRANT_AUX;
                end
            end
            GRANT_AUX: begin
                if (!rx_elig && !aux_elig) begin
                    state_nxt = IDLE;
                end else if (rx_elig && (!aux_elig || (bcnt == BURST_LIM))) begin
                    state_nxt = GRANT_RX;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pops happen only while the grant is held; a cycle that changes the grant
    // pops nothing, which keeps each burst at exactly MAX_BURST words and makes
    // the new grant visible one cycle after the switch decision.
    always_comb begin
        rx_pop  = 1'b0;
        aux_pop = 1'b0;
        if (space && (state_nxt == state)) begin
            case (state)
                GRANT_RX:  rx_pop  = rx_elig;
                GRANT_AUX: aux_pop = aux_elig;
                default: begin
                end
            endcase
        end
    end

    assign RX_FIFO_READ  = rx_pop;
    assign AUX_FIFO_READ = aux_pop;
    assign push          = rx_pop || aux_pop;
    assign push_dat      = rx_pop ? RX_FIFO_DATA : AUX_FIFO_DATA;

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    tjmono2_fwft_buf2 u_out_buf (
        .clk      (FIFO_CLK),
        .rst_n    (FIFO_RST_N),
        .push     (push),
        .push_dat (push_dat),
        .pop      (FIFO_READ),
        .head_dat (FIFO_DATA),
        .empty    (FIFO_EMPTY),
        .full     (buf_full)
    );

    // ------------------------------------------------------------------
    // Per-source word counters
    // ------------------------------------------------------------------
`ifdef TJMONO2_ARB_WORD_CNT_EN
    logic [CNT_WIDTH-1:0] rx_word_cnt;
    logic [CNT_WIDTH-1:0] aux_word_cnt;

    always_ff @(posedge FIFO_CLK or negedge FIFO_RST_N) begin
        if (!FIFO_RST_N) begin
            rx_word_cnt  <= '0;
            aux_word_cnt <= '0;
        end else begin
            if (rx_pop && (rx_word_cnt != '1)) begin
                rx_word_cnt <= rx_word_cnt + 1'b1;
            end
            if (aux_pop && (aux_word_cnt != '1)) begin
                aux_word_cnt <= aux_word_cnt + 1'b1;
            end
        end
    end

    assign RX_WORD_CNT  = rx_word_cnt;
    assign AUX_WORD_CNT = aux_word_cnt;
`else
    assign RX_WORD_CNT  = '0;
    assign AUX_WORD_CNT = '0;
`endif

endmodule : tjmono2_data_arbiter

// File: tb/tb_tjmono2_data_arbiter.sv
// Testbench for tjmono2_data_arbiter: FWFT source models, output scoreboard and
// a burst-order reference computed directly from the round-robin rules.
module tb_tjmono2_data_arbiter;
    import tjmono2_pkg::*;

    localparam int MAXB = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          RX_EN, AUX_EN;
    logic          RX_FIFO_EMPTY, AUX_FIFO_EMPTY;
    logic [31:0]   RX_FIFO_DATA, AUX_FIFO_DATA;
    logic          RX_FIFO_READ, AUX_FIFO_READ;
    logic          FIFO_READ;
    logic          FIFO_EMPTY;
    logic [31:0]   FIFO_DATA;
    logic [CW-1:0] RX_WORD_CNT, AUX_WORD_CNT;

    int checks = 0;
    int errors = 0;

    // Source contents, observations and expectations.
    logic [31:0] rx_q[$];
    logic [31:0] aux_q[$];
    logic [31:0] rx_src_w[$];
    logic [31:0] aux_src_w[$];
    logic [31:0] exp_q[$];
    logic [31:0] out_q[$];
    int          out_cyc[$];
    int          rx_pop_cyc[$];
    int cyc = 0;
    int rx_pop_cnt = 0, aux_pop_cnt = 0, nonempty_seen = 0;
    int rx_viol = 0, aux_viol = 0, dual_viol = 0;
    bit rx_take = 0, aux_take = 0;

    always #5 clk = ~clk;

    tjmono2_data_arbiter #(.MAX_BURST(MAXB), .CNT_WIDTH(CW)) dut (
        .FIFO_CLK       (clk),
        .FIFO_RST_N     (rst_n),
        .RX_EN          (RX_EN),
        .AUX_EN         (AUX_EN),
        .RX_FIFO_EMPTY  (RX_FIFO_EMPTY),
        .RX_FIFO_DATA   (RX_FIFO_DATA),
        .RX_FIFO_READ   (RX_FIFO_READ),
        .AUX_FIFO_EMPTY (AUX_FIFO_EMPTY),
        .AUX_FIFO_DATA  (AUX_FIFO_DATA),
        .AUX_FIFO_READ  (AUX_FIFO_READ),
        .FIFO_READ      (FIFO_READ),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_DATA      (FIFO_DATA),
        .RX_WORD_CNT    (RX_WORD_CNT),
        .AUX_WORD_CNT   (AUX_WORD_CNT)
    );

    task automatic drive_src();
        RX_FIFO_EMPTY  = (rx_q.size() == 0);
        RX_FIFO_DATA   = (rx_q.size() == 0) ? 32'h0 : rx_q[0];
        AUX_FIFO_EMPTY = (aux_q.size() == 0);
        AUX_FIFO_DATA  = (aux_q.size() == 0) ? 32'h0 : aux_q[0];
    endtask

    // Observe everything mid-cycle, where the DUT's combinational outputs are settled.
    always @(negedge clk) begin
        rx_take  = RX_FIFO_READ;
        aux_take = AUX_FIFO_READ;
        if (RX_FIFO_READ) begin
            rx_pop_cnt++;
            rx_pop_cyc.push_back(cyc);
        end
        if (AUX_FIFO_READ) aux_pop_cnt++;
        if (RX_FIFO_READ && (RX_FIFO_EMPTY || !RX_EN)) rx_viol++;
        if (AUX_FIFO_READ && (AUX_FIFO_EMPTY || !AUX_EN)) aux_viol++;
        if (RX_FIFO_READ && AUX_FIFO_READ) dual_viol++;
        if (!FIFO_EMPTY) begin
            nonempty_seen++;
            if (FIFO_READ) begin
                out_q.push_back(FIFO_DATA);
                out_cyc.push_back(cyc);
            end
        end
    end

    // Source FIFOs retire the popped head just after the edge that consumed it.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rx_take && rx_q.size() > 0) void'(rx_q.pop_front());
        if (aux_take && aux_q.size() > 0) void'(aux_q.pop_front());
        rx_take  = 0;
        aux_take = 0;
        drive_src();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        out_q.delete();
        out_cyc.delete();
        rx_pop_cyc.delete();
        rx_pop_cnt    = 0;
        aux_pop_cnt   = 0;
        nonempty_seen = 0;
    endtask

    task automatic load_src();
        foreach (rx_src_w[i]) rx_q.push_back(rx_src_w[i]);
        foreach (aux_src_w[i]) aux_q.push_back(aux_src_w[i]);
        drive_src();
    endtask

    // Wait (bounded) for n output words; optional random downstream stalls.
    task automatic wait_out(input int n, input int budget, input bit rnd);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            if (rnd) FIFO_READ = ($urandom_range(0, 3) != 0);
            tick(1);
            k++;
        end
        FIFO_READ = 1'b1;
        tick(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_q.delete();
        aux_q.delete();
        drive_src();
        FIFO_READ = 1'b0;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        clear_obs();
    endtask

    // Reference order: alternate grants starting with RX; a grant takes up to
    // MAXB words, or everything left if the other source has nothing.
    task automatic build_exp();
        int ri, ai, rrem, arem, k;
        bit turn_rx;
        ri = 0; ai = 0; turn_rx = 1;
        exp_q.delete();
        while (ri < rx_src_w.size() || ai < aux_src_w.size()) begin
            rrem = rx_src_w.size() - ri;
            arem = aux_src_w.size() - ai;
            if (turn_rx) begin
                k = (arem == 0) ? rrem : ((rrem < MAXB) ? rrem : MAXB);
                for (int j = 0; j < k; j++) exp_q.push_back(rx_src_w[ri + j]);
                ri += k;
            end else begin
                k = (rrem == 0) ? arem : ((arem < MAXB) ? arem : MAXB);
                for (int j = 0; j < k; j++) exp_q.push_back(aux_src_w[ai + j]);
                ai += k;
            end
            turn_rx = !turn_rx;
        end
    endtask

    task automatic test_reset();
        checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", FIFO_EMPTY); end
        checks++; if (FIFO_DATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", FIFO_DATA); end
        checks++; if (RX_FIFO_READ !== 1'b0) begin errors++; $display("FAIL reset_rx_read: got %b expected 0", RX_FIFO_READ); end
        checks++; if (AUX_FIFO_READ !== 1'b0) begin errors++; $display("FAIL reset_aux_read: got %b expected 0", AUX_FIFO_READ); end
        checks++; if (RX_WORD_CNT !== '0 || AUX_WORD_CNT !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", RX_WORD_CNT, AUX_WORD_CNT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        clear_obs();
    endtask

    task automatic test_rx_basic();
        int gaps = 0;
        rx_src_w = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
        aux_src_w.delete();
        FIFO_READ = 1'b1;
        load_src();
        wait_out(3, 50, 0);
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== rx_src_w[i]) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", i, out_q[i], rx_src_w[i]); end
        end
        if (out_q.size() == 3 && rx_pop_cyc.size() > 0) begin
            checks++; if (out_cyc[0] - rx_pop_cyc[0] != 1) begin
                errors++; $display("FAIL basic_latency: got %0d cycles expected 1", out_cyc[0] - rx_pop_cyc[0]);
            end
            for (int i = 1; i < 3; i++) if (out_cyc[i] - out_cyc[i-1] != 1) gaps++;
            checks++; if (gaps != 0) begin errors++; $display("FAIL basic_back_to_back: got %0d gaps expected 0", gaps); end
        end
        checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL basic_drained: got %b expected 1", FIFO_EMPTY); end
        clear_obs();
    endtask

    task automatic test_burst();
        int bad = 0;
        rx_src_w.delete();
        aux_src_w.delete();
        for (int i = 0; i < 40; i++) begin
            rx_src_w.push_back(32'hA0000000 + 32'(i + 1));
            aux_src_w.push_back(32'hB0000000 + 32'(i + 1));
        end
        build_exp();
        FIFO_READ = 1'b1;
        load_src();
        wait_out(80, 400, 0);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) begin
            bad++;
            if (bad <= 4) $display("FAIL burst_word%0d: got %h expected %h", i, out_q[i], exp_q[i]);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_order: got %0d wrong words expected 0", bad); end
        clear_obs();
    endtask

    task automatic test_random();
        int nr, na, bad;
        for (int it = 0; it < 6; it++) begin
            nr = $urandom_range(0, 40);
            na = $urandom_range(0, 40);
            rx_src_w.delete();
            aux_src_w.delete();
            for (int i = 0; i < nr; i++) rx_src_w.push_back({4'hA, 28'($urandom)});
            for (int i = 0; i < na; i++) aux_src_w.push_back({4'hB, 28'($urandom)});
            build_exp();
            load_src();
            wait_out(nr + na, 1000, 1);
            bad = 0;
            checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, out_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_order: got %0d wrong words expected 0", it, bad); end
            clear_obs();
        end
    endtask

    task automatic test_backpressure();
        int gaps = 0, bad = 0;
        rx_src_w.delete();
        aux_src_w.delete();
        for (int i = 0; i < 10; i++) rx_src_w.push_back(32'hA1000000 + 32'(i));
        FIFO_READ = 1'b0;
        load_src();
        tick(20);
        checks++; if (rx_pop_cnt != 2) begin errors++; $display("FAIL bp_pops: got %0d expected 2", rx_pop_cnt); end
        checks++; if (RX_FIFO_READ !== 1'b0) begin errors++; $display("FAIL bp_read_held: got %b expected 0", RX_FIFO_READ); end
        checks++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", FIFO_EMPTY); end
        FIFO_READ = 1'b1;
        wait_out(10, 60, 0);
        checks++; if (out_q.size() != 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", out_q.size()); end
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            if (out_q[i] !== rx_src_w[i]) bad++;
            if (i > 0 && out_cyc[i] - out_cyc[i-1] != 1) gaps++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_words: got %0d wrong expected 0", bad); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL bp_throughput: got %0d gaps expected 0", gaps); end
        clear_obs();
    endtask

    task automatic test_enable();
        int bad = 0;
        rx_src_w.delete();
        aux_src_w.delete();
        for (int i = 0; i < 5; i++) aux_src_w.push_back(32'hB2000000 + 32'(i));
        AUX_EN = 1'b0;
        FIFO_READ = 1'b1;
        load_src();
        tick(20);
        checks++; if (aux_pop_cnt != 0) begin errors++; $display("FAIL en_aux_pops: got %0d expected 0", aux_pop_cnt); end
        checks++; if (nonempty_seen != 0) begin errors++; $display("FAIL en_output: got %0d valid cycles expected 0", nonempty_seen); end
        AUX_EN = 1'b1;
        wait_out(5, 40, 0);
        checks++; if (out_q.size() != 5) begin errors++; $display("FAIL en_resume_count: got %0d expected 5", out_q.size()); end
        for (int i = 0; i < 5 && i < out_q.size(); i++) if (out_q[i] !== aux_src_w[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL en_resume_words: got %0d wrong expected 0", bad); end
        clear_obs();
    endtask

    task automatic test_reset_mid();
        int k = 0, bad = 0;
        rx_src_w.delete();
        aux_src_w.delete();
        for (int i = 0; i < 10; i++) rx_src_w.push_back(32'hC0000000 + 32'(i + 1));
        FIFO_READ = 1'b0;
        load_src();
        while (rx_pop_cnt < 2 && k < 20) begin tick(1); k++; end
        tick(3);
        checks++; if (FIFO_EMPTY !== 1'b0 || rx_pop_cnt != 2) begin
            errors++; $display("FAIL rst_mid_fill: got empty=%b pops=%0d expected 0/2", FIFO_EMPTY, rx_pop_cnt);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rst_mid_async_empty: got %b expected 1", FIFO_EMPTY); end
        checks++; if (FIFO_DATA !== 32'h0) begin errors++; $display("FAIL rst_mid_async_data: got %h expected 0", FIFO_DATA); end
        FIFO_READ = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (rx_pop_cnt != 2) begin errors++; $display("FAIL rst_mid_no_pop: got %0d pops expected 2", rx_pop_cnt); end
        rst_n = 1'b1;
        #1;
        // Right after release the arbiter sits in IDLE, so no pop despite RX holding data.
        checks++; if (RX_FIFO_READ !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0", RX_FIFO_READ); end
        @(posedge clk);
        #2;
        out_q.delete();
        out_cyc.delete();
        wait_out(8, 40, 0);
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL rst_mid_count: got %0d expected 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) if (out_q[i] !== rx_src_w[i + 2]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_words: got %0d wrong expected 0", bad); end
        clear_obs();
    endtask

    task automatic test_counters();
        int exp_rx, exp_aux;
        do_reset();
        rx_src_w.delete();
        aux_src_w.delete();
        for (int i = 0; i < 20; i++) rx_src_w.push_back(32'hD0000000 + 32'(i));
        FIFO_READ = 1'b1;
        load_src();
        wait_out(20, 80, 0);
`ifdef TJMONO2_ARB_WORD_CNT_EN
        exp_rx = (rx_src_w.size() > 15) ? 15 : rx_src_w.size();
        exp_aux = 0;
`else
        exp_rx = 0;
        exp_aux = 0;
`endif
        checks++; if (out_q.size() != 20) begin errors++; $display("FAIL cnt_forwarded: got %0d expected 20", out_q.size()); end
        checks++; if (int'(RX_WORD_CNT) != exp_rx) begin errors++; $display("FAIL cnt_rx: got %0d expected %0d", RX_WORD_CNT, exp_rx); end
        checks++; if (int'(AUX_WORD_CNT) != exp_aux) begin errors++; $display("FAIL cnt_aux_zero: got %0d expected %0d", AUX_WORD_CNT, exp_aux); end
        rx_src_w.delete();
        for (int i = 0; i < 3; i++) aux_src_w.push_back(32'hB3000000 + 32'(i));
        load_src();
        wait_out(23, 40, 0);
`ifdef TJMONO2_ARB_WORD_CNT_EN
        exp_aux = aux_src_w.size();
`endif
        checks++; if (int'(AUX_WORD_CNT) != exp_aux) begin errors++; $display("FAIL cnt_aux: got %0d expected %0d", AUX_WORD_CNT, exp_aux); end
        checks++; if (int'(RX_WORD_CNT) != exp_rx) begin errors++; $display("FAIL cnt_rx_hold: got %0d expected %0d", RX_WORD_CNT, exp_rx); end
        clear_obs();
    endtask

    task automatic test_protocol();
        checks++; if (rx_viol != 0) begin errors++; $display("FAIL proto_rx: got %0d illegal pops expected 0", rx_viol); end
        checks++; if (aux_viol != 0) begin errors++; $display("FAIL proto_aux: got %0d illegal pops expected 0", aux_viol); end
        checks++; if (dual_viol != 0) begin errors++; $display("FAIL proto_dual: got %0d dual pops expected 0", dual_viol); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RX_EN = 1'b1;
        AUX_EN = 1'b1;
        FIFO_READ = 1'b0;
        drive_src();
        tick(3);
        test_reset();
        test_rx_basic();
        test_burst();
        test_random();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_counters();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tjmono2_data_arbiter
